// File: rtl/agu_seq_pkg.sv
// Shared definitions for the address-generation unit: operation codes,
// branch condition codes, FSM states and the branch-offset sign extender.
package agu_seq_pkg;

    // func[5:3] when func[5] == 0: control-transfer class
    typedef enum logic [2:0] {
        F_JMP   = 3'b000,
        F_JMPR  = 3'b001,
        F_JMPC  = 3'b010,
        F_JMPRC = 3'b011
    } jmp_op_e;

    // func[5:2] when func[5] == 1; func[1:0] are don't-care
    typedef enum logic [3:0] {
        F_LOAD  = 4'b1000,
        F_STORE = 4'b1001,
        F_LOADC = 4'b1010,
        F_CALL  = 4'b1011,
        F_RET   = 4'b1100
    } ctl_op_e;

    // func[2:0] for conditional jumps, S1 treated as signed; 11x never taken
    typedef enum logic [2:0] {
        C_LT = 3'b000,
        C_GE = 3'b001,
        C_EQ = 3'b010,
        C_NE = 3'b011,
        C_GT = 3'b100,
        C_LE = 3'b101
    } cond_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEM  = 1'b1
    } state_e;

    // Sign-extend the low w bits of v (1 <= w <= 8) to a full byte.
    function automatic logic [7:0] sext_off(input logic [7:0] v, input int unsigned w);
        logic signed [7:0] t;
        t = v << (8 - w);
        return t >>> (8 - w);
    endfunction

endpackage

// File: rtl/agu_ras.sv
// Return-address stack for agu_seq: circular buffer of DEPTH entries.
//   clk, rst    : clock, asynchronous active-high reset
//   push, pop   : stack operations (mutually exclusive)
//   push_data   : value pushed
//   top_data    : most recently pushed value (valid when !empty)
//   empty       : no entries held
//   ovf, unf    : sticky flags, push on full / pop on empty
// A push on a full stack overwrites the oldest entry: the write pointer has
// wrapped onto it, so the count saturates while the pointer keeps moving.
module agu_ras
    import agu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         empty,
    output logic         ovf,
    output logic         unf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] sp;      // next free slot
    logic [CW-1:0] cnt;
    logic          full;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign top_data = mem[sp - PW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            sp <= sp + PW'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                sp  <= sp - PW'(1);
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/agu_seq.sv
// Sequential address-generation unit: owns the PC, resolves jumps, branches
// and CALL/RET through agu_ras, and drives a req/ack data memory port for
// LOAD/STORE. Issue stalls while a memory access is outstanding.
//   clk, rst         : clock, asynchronous active-high reset
//   issue_valid/ready: instruction handshake
//   func, S1, S2, imm: operation code, operands, 8-bit immediate (the
//                      instruction's "const" field; const is a reserved word)
//   pc               : registered program counter
//   mem_req/we/addr/wdata, mem_rdata/ack : data memory port
//   res_valid/res_data : one-cycle LOAD/LOADC result
//   ras_ovf/ras_unf  : sticky return-stack overflow/underflow
module agu_seq
    import agu_seq_pkg::*;
#(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 32,
    parameter int unsigned OFFS_W    = 6,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [5:0]      func,
    input  logic [DW-1:0]   S1,
    input  logic [DW-1:0]   S2,
    input  logic [7:0]      imm,
    output logic [PC_W-1:0] pc,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            res_valid,
    output logic [DW-1:0]   res_data,
    output logic            ras_ovf,
    output logic            ras_unf
);

    state_e          state, state_n;
    logic [PC_W-1:0] pc_n, pc_inc, off_ext, ras_top;
    logic            we_n, res_valid_n, accept, taken, ras_push, ras_pop, ras_empty;
    logic [AW-1:0]   addr_n;
    logic [DW-1:0]   wdata_n, res_data_n;
    logic signed [7:0] off8;
    logic            s1_neg, s1_zero;

    // mem_req is the MEM state itself, so an asynchronous reset drops it at once
    assign mem_req     = (state == S_MEM);
    assign issue_ready = (state == S_IDLE) && !rst;
    assign accept      = issue_valid && issue_ready;

    assign off8    = sext_off(imm, OFFS_W);
    assign off_ext = PC_W'(off8);
    assign pc_inc  = pc + PC_W'(1);
    assign s1_neg  = S1[DW-1];
    assign s1_zero = (S1 == '0);

    always_comb begin
        taken = 1'b0;
        case (func[2:0])
            C_LT:    taken = s1_neg;
            C_GE:    taken = !s1_neg;
            C_EQ:    taken = s1_zero;
            C_NE:    taken = !s1_zero;
            C_GT:    taken = !s1_neg && !s1_zero;
            C_LE:    taken = s1_neg || s1_zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        we_n        = mem_we;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        res_valid_n = 1'b0;
        res_data_n  = res_data;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        if (state == S_IDLE) begin
            if (accept) begin
                if (!func[5]) begin
                    case (func[5:3])
                        F_JMP:   pc_n = S1[PC_W-1:0];
                        F_JMPR:  pc_n = pc + off_ext;
                        F_JMPC:  pc_n = taken ? S2[PC_W-1:0] : pc_inc;
                        F_JMPRC: pc_n = taken ? (pc + off_ext) : pc_inc;
                        default: pc_n = pc_inc;
                    endcase
                end else begin
                    case (func[5:2])
                        F_LOAD, F_STORE: begin
                            state_n = S_MEM;
                            addr_n  = S1[AW-1:0];
                            we_n    = (func[5:2] == F_STORE);
                            wdata_n = (func[5:2] == F_STORE) ? S2 : '0;
                        end
                        F_LOADC: begin
                            res_valid_n = 1'b1;
                            res_data_n  = {S1[DW-1:8], imm};
                            pc_n        = pc_inc;
                        end
                        F_CALL: begin
                            ras_push = 1'b1;
                            pc_n     = S1[PC_W-1:0];
                        end
                        F_RET: begin
                            ras_pop = 1'b1;
                            pc_n    = ras_empty ? pc_inc : ras_top;
                        end
                        default: pc_n = pc_inc;
                    endcase
                end
            end
        end else begin
            if (mem_ack) begin
                state_n = S_IDLE;
                pc_n    = pc_inc;
                if (!mem_we) begin
                    res_valid_n = 1'b1;
                    res_data_n  = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= PC_W'(RESET_PC);
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            res_valid <= res_valid_n;
            res_data  <= res_data_n;
        end
    end

    agu_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule
